crossover_mutate_pipe: RTL and testbench
========================================

# crossover_mutate_pipe

Parametrised, stall-capable successor to the single-shot crossover/perturb stage of the NEAT reproduction datapath. Takes a per-genome configuration (parent fitnesses, child ID, per-attribute mutation probabilities for node and connection genes), then streams aligned parent-gene pairs through a two-stage crossover → mutate pipeline with valid/ready handshakes on both sides. A genome-level FSM brackets each child genome with configuration and drain phases. Sits between the parent-gene fetch/alignment unit and the child-genome writer.

## Interface
- ATTR_SZ, 8, width of one attribute field
- NUM_ATTR, 4, mutable attributes per gene (≥1)
- GENE_SZ, (NUM_ATTR+4)*ATTR_SZ, gene width; layout MSB→LSB: ID[1 field] | KEY[2 fields] | TYPE[1 field] | ATTR[NUM_ATTR-1..0]
- STAT_W, 16, statistics counter width
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  configuration accepted when both high
- cfg_data  in  (2*NUM_ATTR+3)*ATTR_SZ  MSB→LSB: fit1 | fit2 | child_id | node_prob[NUM_ATTR-1..0] | conn_prob[NUM_ATTR-1..0]
- in_valid, in_ready  in/out  1  parent-pair handshake
- in_gene1, in_gene2  in  GENE_SZ  aligned parent genes
- in_last  in  1  final pair of this genome
- in_rand  in  3*NUM_ATTR*ATTR_SZ  MSB→LSB: mut_val | mut_cmp | xsel fields; sampled with pair
- out_valid, out_ready  out/in  1  child-gene handshake
- out_gene  out  GENE_SZ  child gene
- out_last  out  1  final child gene of genome
- stat_genes, stat_muts  out  STAT_W  statistics (see Configuration)

## Operation
- FSM IDLE → RUN → DRAIN → IDLE. cfg_ready = (state==IDLE). cfg handshake: registers fields, clears statistics, → RUN.
- RUN: pairs accepted per handshake; accepting a pair with in_last → DRAIN. cfg_valid ignored outside IDLE.
- DRAIN: in_ready=0; → IDLE in the cycle after the out handshake with out_last.
- Fitter parent: parent2 if fit2 > fit1, else parent1 (tie → parent1).
- Stage 1 (crossover): if KEY1==KEY2, ATTR[i] from parent2 when xsel[i] bit0=1, else parent1; if keys differ, all ATTR from fitter. ID/KEY/TYPE carried from fitter.
- gene type = TYPE field bit0 of fitter (0 node, 1 conn); prob[i] = node_prob[i] or conn_prob[i].
- Stage 2 (mutate): ATTR[i] = mut_val[i] if mut_cmp[i] < prob[i] (unsigned) else crossover value. prob 0 never mutates. ID field replaced by child_id.
- Each stage: advance when empty or downstream accepts; s2_adv = !s2_v | out_ready; s1_adv = !s1_v | s2_adv; in_ready = (state==RUN) & s1_adv. Random fields travel with their pair.

## Timing
- Reset: state IDLE, cfg_ready=1, in_ready=0, out_valid=0, out_gene=0, out_last=0, stats 0, config registers 0, both stage valids cleared. Reset mid-genome discards all in-flight genes.
- Latency: pair accepted at edge N → out_valid at edge N+2 absent backpressure. Throughput 1 gene/cycle.
- out_gene/out_last stable while out_valid & !out_ready. No loss, duplication or reordering under any out_ready pattern.
- cfg accepted at edge N → in_ready may assert from cycle N+1.
- in_last with one-gene genome valid; genome of zero genes impossible (RUN exits only on in_last).

## Configuration
- CROSSOVER_STATS_EN defined: stat_genes counts out handshakes, stat_muts adds the number of mutated attributes per output gene; both saturate at 2^STAT_W−1, clear on rst and cfg handshake.
- Undefined: counters not built; stat_genes, stat_muts tied to 0.

## Test plan
- Reset 2 cycles → cfg_ready=1, in_ready=0, out_valid=0, out_gene=0.
- Cfg fit1=0x10, fit2=0x20, id=0x07, probs 0; KEY both 0x1234, attrs g1=0x11223344, g2=0xAABBCCDD, xsel bit0 attr3..0 = 1,0,1,0 → out_gene attrs 0xAA22CC44, ID 0x07, KEY 0x1234, out_valid 2 cycles after accept.
- Same but KEY2=0x1235 → attrs 0xAABBCCDD, KEY 0x1235 (fitter parent2).
- Node gene, node_prob all 0x80, mut_cmp attr3..0 = 0xFF,0x00,0x80,0x7F, mut_val 0x55 → attrs 0xAA55CC55 (attr0, attr2 mutated); stat_muts=2 with macro.
- Stream 4 pairs, out_ready low 3 cycles → in_ready drops once both stages hold, outputs arrive in order, none lost/duplicated.
- in_last on 3rd pair → in_ready=0 next cycle, cfg_ready=1 cycle after third out handshake, stat_genes=3 (0 without macro); rst asserted mid-stream → out_valid=0 next cycle.

Source files
------------

// File: rtl/crossover_mutate_pipe.sv
// NEAT crossover -> mutate pipeline with per-genome configuration and valid/ready streaming.
// Optional statistics counters are built when CROSSOVER_STATS_EN is defined.
module crossover_mutate_pipe #(
  parameter int unsigned ATTR_SZ  = 8,
  parameter int unsigned NUM_ATTR = 4,
  parameter int unsigned GENE_SZ  = (NUM_ATTR + 4) * ATTR_SZ,
  parameter int unsigned STAT_W   = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   cfg_valid,
  output logic                                   cfg_ready,
  input  logic [(2*NUM_ATTR+3)*ATTR_SZ-1:0]      cfg_data,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [GENE_SZ-1:0]                     in_gene1,
  input  logic [GENE_SZ-1:0]                     in_gene2,
  input  logic                                   in_last,
  input  logic [3*NUM_ATTR*ATTR_SZ-1:0]          in_rand,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [GENE_SZ-1:0]                     out_gene,
  output logic                                   out_last,
  output logic [STAT_W-1:0]                      stat_genes,
  output logic [STAT_W-1:0]                      stat_muts
);

  localparam int unsigned VEC_W    = NUM_ATTR * ATTR_SZ;
  localparam int unsigned TYPE_LSB = VEC_W;
  localparam int unsigned KEY_LSB  = VEC_W + ATTR_SZ;
  localparam int unsigned KEY_W    = 2 * ATTR_SZ;
  localparam int unsigned ID_LSB   = VEC_W + 3 * ATTR_SZ;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state;
  logic [ATTR_SZ-1:0] fit1, fit2, child_id;
  logic [VEC_W-1:0]   node_prob, conn_prob;

  logic               s1_v, s1_last;
  logic [GENE_SZ-1:0] s1_gene;
  logic [VEC_W-1:0]   s1_mval, s1_mcmp;

  logic s1_adv, s2_adv, in_hs, out_hs;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_v || s2_adv;
  assign in_ready = (state == RUN) && s1_adv;
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;

  // Genome-level sequencing; cfg_ready mirrors the IDLE state as a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cfg_ready <= 1'b1;
      fit1      <= '0;
      fit2      <= '0;
      child_id  <= '0;
      node_prob <= '0;
      conn_prob <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            {fit1, fit2, child_id, node_prob, conn_prob} <= cfg_data;
            state     <= RUN;
            cfg_ready <= 1'b0;
          end
        end
        RUN: begin
          if (in_hs && in_last) state <= DRAIN;
        end
        DRAIN: begin
          if (out_hs && out_last) begin
            state     <= IDLE;
            cfg_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

  // Crossover: matching keys pick each attribute by xsel bit0, otherwise inherit from the fitter parent.
  logic [GENE_SZ-1:0] fit_gene, xover;
  logic               keys_eq;

  always_comb begin
    fit_gene = (fit2 > fit1) ? in_gene2 : in_gene1;
    keys_eq  = in_gene1[KEY_LSB +: KEY_W] == in_gene2[KEY_LSB +: KEY_W];
    xover    = fit_gene;
    for (int unsigned i = 0; i < NUM_ATTR; i++) begin
      if (keys_eq)
        xover[i*ATTR_SZ +: ATTR_SZ] = in_rand[i*ATTR_SZ] ? in_gene2[i*ATTR_SZ +: ATTR_SZ]
                                                         : in_gene1[i*ATTR_SZ +: ATTR_SZ];
    end
  end

  // Only bit0 of each xsel field steers the crossover.
  logic [NUM_ATTR*(ATTR_SZ-1)-1:0] unused_xsel;
  always_comb begin
    unused_xsel = '0;
    for (int unsigned i = 0; i < NUM_ATTR; i++)
      unused_xsel[i*(ATTR_SZ-1) +: ATTR_SZ-1] = in_rand[i*ATTR_SZ+1 +: ATTR_SZ-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_last <= 1'b0;
      s1_gene <= '0;
      s1_mval <= '0;
      s1_mcmp <= '0;
    end else if (s1_adv) begin
      s1_v <= in_hs;
      if (in_hs) begin
        s1_last <= in_last;
        s1_gene <= xover;
        s1_mval <= in_rand[2*VEC_W +: VEC_W];
        s1_mcmp <= in_rand[VEC_W +: VEC_W];
      end
    end
  end

  // Mutation: probability set chosen by gene type; ID becomes the child's.
  logic [VEC_W-1:0]    prob;
  logic [NUM_ATTR-1:0] mut_mask;
  logic [GENE_SZ-1:0]  mutated;

  always_comb begin
    prob     = s1_gene[TYPE_LSB] ? conn_prob : node_prob;
    mutated  = s1_gene;
    mut_mask = '0;
    mutated[ID_LSB +: ATTR_SZ] = child_id;
    for (int unsigned i = 0; i < NUM_ATTR; i++) begin
      mut_mask[i] = s1_mcmp[i*ATTR_SZ +: ATTR_SZ] < prob[i*ATTR_SZ +: ATTR_SZ];
      if (mut_mask[i])
        mutated[i*ATTR_SZ +: ATTR_SZ] = s1_mval[i*ATTR_SZ +: ATTR_SZ];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_gene  <= '0;
      out_last  <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_v;
      if (s1_v) begin
        out_gene <= mutated;
        out_last <= s1_last;
      end
    end
  end

`ifdef CROSSOVER_STATS_EN
  logic [NUM_ATTR-1:0] out_mask;
  logic [STAT_W:0]     muts_sum;

  assign muts_sum = {1'b0, stat_muts} + (STAT_W+1)'($countones(out_mask));

  // Saturating per-genome counters, restarted by each configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_mask   <= '0;
      stat_genes <= '0;
      stat_muts  <= '0;
    end else begin
      if (s2_adv && s1_v) out_mask <= mut_mask;
      if (cfg_valid && cfg_ready) begin
        stat_genes <= '0;
        stat_muts  <= '0;
      end else if (out_hs) begin
        if (stat_genes != {STAT_W{1'b1}}) stat_genes <= stat_genes + STAT_W'(1);
        stat_muts <= muts_sum[STAT_W] ? {STAT_W{1'b1}} : muts_sum[STAT_W-1:0];
      end
    end
  end
`else
  assign stat_genes = '0;
  assign stat_muts  = '0;
`endif

endmodule

// File: tb/tb_crossover_mutate_pipe.sv
// Scoreboard bench for crossover_mutate_pipe: reference model fills a queue at input
// handshakes, a negedge monitor pops and compares at output handshakes.
module tb_crossover_mutate_pipe;
  localparam int unsigned A  = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned G  = (N + 4) * A;
  localparam int unsigned SW = 16;
  localparam int unsigned CW = (2 * N + 3) * A;
  localparam int unsigned RW = 3 * N * A;
`ifdef CROSSOVER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk, rst;
  logic          cfg_valid, cfg_ready;
  logic [CW-1:0] cfg_data;
  logic          in_valid, in_ready, in_last;
  logic [G-1:0]  in_gene1, in_gene2;
  logic [RW-1:0] in_rand;
  logic          out_valid, out_ready, out_last;
  logic [G-1:0]  out_gene;
  logic [SW-1:0] stat_genes, stat_muts;

  crossover_mutate_pipe #(.ATTR_SZ(A), .NUM_ATTR(N), .GENE_SZ(G), .STAT_W(SW)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_gene1(in_gene1), .in_gene2(in_gene2),
    .in_last(in_last), .in_rand(in_rand),
    .out_valid(out_valid), .out_ready(out_ready), .out_gene(out_gene), .out_last(out_last),
    .stat_genes(stat_genes), .stat_muts(stat_muts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [A-1:0]   c_fit1, c_fit2, c_id;
  logic [N*A-1:0] c_node, c_conn;
  int             exp_genes, exp_muts;
  logic [G:0]     sb_q[$];

  function automatic logic [G-1:0] model(input logic [G-1:0] g1, input logic [G-1:0] g2,
                                         input logic [RW-1:0] rnd, output int nmut);
    logic [G-1:0] fit, r;
    logic [A-1:0] p, cmp, val;
    fit  = (c_fit2 > c_fit1) ? g2 : g1;
    r    = fit;
    nmut = 0;
    for (int i = 0; i < N; i++) begin
      if (g1[G-A-1 -: 2*A] == g2[G-A-1 -: 2*A])
        r[i*A +: A] = rnd[i*A] ? g2[i*A +: A] : g1[i*A +: A];
      p   = fit[N*A] ? c_conn[i*A +: A] : c_node[i*A +: A];
      cmp = rnd[(N+i)*A +: A];
      val = rnd[(2*N+i)*A +: A];
      if (cmp < p) begin
        r[i*A +: A] = val;
        nmut++;
      end
    end
    r[G-1 -: A] = c_id;
    return r;
  endfunction

  function automatic logic [G-1:0] rand_gene();
    logic [G-1:0] g;
    g = {$urandom(), $urandom()};
    g[G-A-1 -: 2*A] = ($urandom_range(0, 1) == 1) ? 16'h00AA : 16'h00AB;
    return g;
  endfunction

  task automatic do_cfg(input logic [A-1:0] f1, input logic [A-1:0] f2, input logic [A-1:0] id,
                        input logic [N*A-1:0] node, input logic [N*A-1:0] conn);
    bit ok = 0;
    c_fit1 = f1; c_fit2 = f2; c_id = id; c_node = node; c_conn = conn;
    exp_genes = 0; exp_muts = 0;
    cfg_data  = {f1, f2, id, node, conn};
    cfg_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (cfg_ready) begin ok = 1; break; end
    end
    if (!ok) check("cfg_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic send(input logic [G-1:0] g1, input logic [G-1:0] g2,
                      input logic [RW-1:0] rnd, input logic last);
    bit ok = 0;
    int nm;
    logic [G-1:0] e;
    in_gene1 = g1; in_gene2 = g2; in_rand = rnd; in_last = last; in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) check("in_timeout", 64'd0, 64'd1);
    else begin
      e = model(g1, g2, rnd, nm);
      sb_q.push_back({last, e});
      exp_genes++;
      exp_muts += nm;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_last_out();
    bit ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (out_valid && out_ready && out_last) begin ok = 1; break; end
    end
    if (!ok) check("last_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_genes"}, 64'(stat_genes), STATS ? 64'(exp_genes) : 64'd0);
    check({tag, "_muts"},  64'(stat_muts),  STATS ? 64'(exp_muts)  : 64'd0);
  endtask

  // Output monitor: scoreboard pop plus hold-stability under backpressure
  bit           held = 0;
  logic [G-1:0] held_gene;
  logic         held_last;
  logic [G:0]   exp_e;

  always @(negedge clk) begin
    if (rst) begin
      held = 0;
    end else begin
      if (held) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_gene", out_gene, held_gene);
        check("hold_last", 64'(out_last), 64'(held_last));
      end
      held      = out_valid && !out_ready;
      held_gene = out_gene;
      held_last = out_last;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) check("unexpected_out", 64'd1, 64'd0);
        else begin
          exp_e = sb_q.pop_front();
          check("out_gene", out_gene, exp_e[G-1:0]);
          check("out_last", 64'(out_last), 64'(exp_e[G]));
        end
      end
    end
  end

  logic [G-1:0]  g1, g2;
  logic [RW-1:0] rnd;
  bit            stream_done;

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_data = '0; in_valid = 1'b0; in_last = 1'b0;
    in_gene1 = '0; in_gene2 = '0; in_rand = '0; out_ready = 1'b1;
    c_fit1 = '0; c_fit2 = '0; c_id = '0; c_node = '0; c_conn = '0;
    exp_genes = 0; exp_muts = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_gene", out_gene, 64'd0);
    check_stats("rst");
    rst = 1'b0;

    // Matching keys: per-attribute xsel selection, latency
    do_cfg(8'h10, 8'h20, 8'h07, '0, '0);
    check("cfg_in_ready", 64'(in_ready), 64'd1);
    check("cfg_busy", 64'(cfg_ready), 64'd0);
    g1  = {8'h01, 16'h1234, 8'h00, 32'h11223344};
    g2  = {8'h02, 16'h1234, 8'h00, 32'hAABBCCDD};
    rnd = {32'h0, 32'h0, 32'h01000100};
    send(g1, g2, rnd, 1'b1);
    check("lat_n1_valid", 64'(out_valid), 64'd0);
    check("drain_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    check("lat_n2_valid", 64'(out_valid), 64'd1);
    check("xover_attrs", 64'(out_gene[31:0]), 64'hAA22CC44);
    check("xover_id", 64'(out_gene[63:56]), 64'h07);
    check("xover_key", 64'(out_gene[55:40]), 64'h1234);
    wait_last_out();
    check("a_cfg_ready", 64'(cfg_ready), 64'd1);

    // Differing keys: everything from the fitter parent2
    do_cfg(8'h10, 8'h20, 8'h07, '0, '0);
    g2 = {8'h02, 16'h1235, 8'h00, 32'hAABBCCDD};
    send(g1, g2, rnd, 1'b1);
    @(posedge clk); #1;
    check("fitter_attrs", 64'(out_gene[31:0]), 64'hAABBCCDD);
    check("fitter_key", 64'(out_gene[55:40]), 64'h1235);
    wait_last_out();

    // Mutation on a node gene; a conn gene with zero conn_prob is untouched
    do_cfg(8'h10, 8'h20, 8'h07, {4{8'h80}}, '0);
    g2  = {8'h02, 16'h1234, 8'h00, 32'hAABBCCDD};
    rnd = {32'h55555555, 32'hFF00807F, 32'h01000100};
    send(g1, g2, rnd, 1'b0);
    send({8'h01, 16'h1234, 8'h01, 32'h11223344}, {8'h02, 16'h1234, 8'h01, 32'hAABBCCDD}, rnd, 1'b1);
    check("mut_node_attrs", 64'(out_gene[31:0]), 64'hAA55CC55);
    @(posedge clk); #1;
    check("mut_conn_attrs", 64'(out_gene[31:0]), 64'hAA22CC44);
    wait_last_out();
    check("mut_stat_muts", 64'(stat_muts), STATS ? 64'd2 : 64'd0);
    check_stats("mut");

    // Backpressure: both stages fill, in_ready drops, order preserved; tied fitness
    do_cfg(8'h30, 8'h30, 8'h5A, {$urandom(), 8'h0} >> 8, {$urandom(), 8'h0} >> 8);
    out_ready = 1'b0;
    send(rand_gene(), rand_gene(), {$urandom(), $urandom(), $urandom()}, 1'b0);
    send(rand_gene(), rand_gene(), {$urandom(), $urandom(), $urandom()}, 1'b0);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    check("stall_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    check("stall_in_ready2", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    send(rand_gene(), rand_gene(), {$urandom(), $urandom(), $urandom()}, 1'b0);
    send(rand_gene(), rand_gene(), {$urandom(), $urandom(), $urandom()}, 1'b1);
    wait_last_out();
    check("bp_cfg_ready", 64'(cfg_ready), 64'd1);
    check_stats("bp");

    // Three-gene genome: last on third pair
    do_cfg(8'h40, 8'h08, 8'h33, {4{8'h60}}, {4{8'hA0}});
    for (int i = 0; i < 3; i++)
      send(rand_gene(), rand_gene(), {$urandom(), $urandom(), $urandom()}, i == 2);
    check("last_in_ready", 64'(in_ready), 64'd0);
    check("last_cfg_busy", 64'(cfg_ready), 64'd0);
    wait_last_out();
    check("three_cfg_ready", 64'(cfg_ready), 64'd1);
    check("three_stat_genes", 64'(stat_genes), STATS ? 64'd3 : 64'd0);

    // Long genome under random out_ready
    do_cfg(8'($urandom()), 8'($urandom()), 8'h21, {$urandom()}, {$urandom()});
    stream_done = 0;
    fork
      begin
        for (int i = 0; i < 24; i++)
          send(rand_gene(), rand_gene(), {$urandom(), $urandom(), $urandom()}, i == 23);
        wait_last_out();
        stream_done = 1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready = 1'b1;
    check("rand_cfg_ready", 64'(cfg_ready), 64'd1);
    check_stats("rand");

    // Reset mid-genome discards in-flight genes
    do_cfg(8'h01, 8'h02, 8'h44, '0, '0);
    out_ready = 1'b0;
    send(rand_gene(), rand_gene(), {$urandom(), $urandom(), $urandom()}, 1'b0);
    send(rand_gene(), rand_gene(), {$urandom(), $urandom(), $urandom()}, 1'b0);
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check("mid_rst_cfg_ready", 64'(cfg_ready), 64'd1);
    check("mid_rst_gene", out_gene, 64'd0);
    sb_q.delete();
    exp_genes = 0; exp_muts = 0;
    check_stats("mid_rst");
    rst = 1'b0;
    out_ready = 1'b1;

    // Recovery after reset
    do_cfg(8'h90, 8'h10, 8'h66, {4{8'hFF}}, '0);
    send({8'h01, 16'h0001, 8'h00, 32'h01020304}, {8'h02, 16'h0002, 8'h00, 32'h0A0B0C0D},
         {32'hDEADBEEF, 32'h00FF00FF, 32'h0}, 1'b1);
    wait_last_out();
    check_stats("recover");
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
